spectrum_peak_finder: RTL

- Parametrised successor to the 16-bin frequency analysis stage.
- Accepts FFT output frames of N_BINS complex bins, streamed one bin per cycle over a valid/ready handshake.
- Computes power re²+im² in a 2-stage pipeline and tracks the maximum across the frame.
- Presents the peak bin index and peak power on a held valid/ready result port; feeds the frequency decision logic downstream.

---
 rtl/spectrum_peak_finder_pkg.sv | 17 +
 rtl/spectrum_peak_finder_cplx_power.sv | 62 ++++++
 rtl/spectrum_peak_finder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/spectrum_peak_finder_pkg.sv
// Shared types and helpers for the spectrum peak finder.
// FSM states, pipeline depth and the power-width rule.
package spf_pkg;

   typedef enum logic [1:0] {
      ACCUM,
      FLUSH,
      HOLD
   } spf_state_e;

   localparam int PIPE_DEPTH = 3;

   function automatic int pw_of(input int dw);
      return 2 * dw;
   endfunction

endpackage

// File: rtl/spectrum_peak_finder_cplx_power.sv
// Two-stage registered complex power re^2 + im^2.
// Valid and a bin index travel alongside the data.
module cplx_power #(
   parameter int DW = 16,
   parameter int IW = 4,
   parameter int PW = 2 * DW
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 sclr,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] in_re,
   input  logic signed [DW-1:0] in_im,
   input  logic [IW-1:0]        in_idx,
   output logic                 out_valid,
   output logic [IW-1:0]        out_idx,
   output logic [PW-1:0]        out_pwr
);

   // A square is at most 2^(PW-2), so PW-1 bits hold it without wrap.
   logic signed [PW-2:0] re_x;
   logic signed [PW-2:0] im_x;
   logic [PW-2:0]        re_sq_d;
   logic [PW-2:0]        im_sq_d;
   logic [PW-2:0]        re_sq;
   logic [PW-2:0]        im_sq;
   logic [IW-1:0]        s1_idx;
   logic                 s1_valid;

   assign re_x    = (PW-1)'(in_re);
   assign im_x    = (PW-1)'(in_im);
   assign re_sq_d = re_x * re_x;
   assign im_sq_d = im_x * im_x;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s1_valid  <= 1'b0;
         s1_idx    <= '0;
         re_sq     <= '0;
         im_sq     <= '0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_pwr   <= '0;
      end else if (sclr) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         s1_valid  <= in_valid;
         out_valid <= s1_valid;
         if (in_valid) begin
            re_sq  <= re_sq_d;
            im_sq  <= im_sq_d;
            s1_idx <= in_idx;
         end
         if (s1_valid) begin
            out_pwr <= {1'b0, re_sq} + {1'b0, im_sq};
            out_idx <= s1_idx;
         end
      end
   end

endmodule

// File: rtl/spectrum_peak_finder.sv
// Frame-wise peak power finder over streamed FFT bins.
// Optional noise threshold compare under SPF_THRESHOLD_EN.
module spectrum_peak_finder
   import spf_pkg::*;
#(
   parameter int N_BINS = 16,
   parameter int DW     = 16,
   parameter int IDX_W  = $clog2(N_BINS),
   parameter int PW     = pw_of(DW)
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 sclr,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] in_re,
   input  logic signed [DW-1:0] in_im,
`ifdef SPF_THRESHOLD_EN
   input  logic [PW-1:0]        thr,
   output logic                 out_noise,
`endif
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [IDX_W-1:0]     out_idx,
   output logic [PW-1:0]        out_pwr,
   output logic [15:0]          out_frames
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(N_BINS - 1);

   spf_state_e       state_q;
   spf_state_e       state_d;
   logic [IDX_W-1:0] cnt;
   logic             accept;
   logic             p_valid;
   logic [IDX_W-1:0] p_idx;
   logic [PW-1:0]    p_pwr;
   logic [PW-1:0]    max_pwr;
   logic [IDX_W-1:0] max_idx;
   logic             cmp_last;

   assign in_ready = (state_q == ACCUM);
   assign accept   = in_valid && in_ready;

   cplx_power #(
      .DW (DW),
      .IW (IDX_W),
      .PW (PW)
   ) u_pwr (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .sclr      (sclr),
      .in_valid  (accept),
      .in_re     (in_re),
      .in_im     (in_im),
      .in_idx    (cnt),
      .out_valid (p_valid),
      .out_idx   (p_idx),
      .out_pwr   (p_pwr)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ACCUM: if (accept && cnt == LAST) state_d = FLUSH;
         FLUSH: if (cmp_last) state_d = HOLD;
         HOLD:  if (out_ready) state_d = ACCUM;
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ACCUM;
         cnt     <= '0;
      end else if (sclr) begin
         state_q <= ACCUM;
         cnt     <= '0;
      end else begin
         state_q <= state_d;
         if (accept) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   // Bin 0 always loads, so ties and all-zero frames resolve low.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         max_pwr  <= '0;
         max_idx  <= '0;
         cmp_last <= 1'b0;
      end else if (sclr) begin
         max_pwr  <= '0;
         max_idx  <= '0;
         cmp_last <= 1'b0;
      end else begin
         cmp_last <= p_valid && (p_idx == LAST);
         if (p_valid && (p_idx == '0 || p_pwr > max_pwr)) begin
            max_pwr <= p_pwr;
            max_idx <= p_idx;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         out_valid  <= 1'b0;
         out_idx    <= '0;
         out_pwr    <= '0;
         out_frames <= '0;
      end else if (sclr) begin
         out_valid  <= 1'b0;
         out_idx    <= '0;
         out_pwr    <= '0;
      end else if (state_q == FLUSH && cmp_last) begin
         out_valid  <= 1'b1;
         out_idx    <= max_idx;
         out_pwr    <= max_pwr;
         out_frames <= out_frames + 16'd1;
      end else if (state_q == HOLD && out_ready) begin
         out_valid  <= 1'b0;
      end
   end

`ifdef SPF_THRESHOLD_EN
   logic [PW-1:0] thr_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         thr_q     <= '0;
         out_noise <= 1'b0;
      end else if (sclr) begin
         thr_q     <= '0;
         out_noise <= 1'b0;
      end else begin
         if (state_q == ACCUM && state_d == FLUSH) thr_q <= thr;
         if (state_q == FLUSH && cmp_last) out_noise <= (max_pwr < thr_q);
      end
   end
`endif

endmodule
